pq_drain_ctrl: RTL and testbench



---
 rtl/pq_buffer_pkg.sv | 14 +
 rtl/pq_drain_ctrl_if.sv | 30 +++
 rtl/pq_skid_q.sv | 54 +++++
 rtl/pq_drain_ctrl.sv | 166 ++++++++++++++++
 tb/tb_pq_drain_ctrl.sv | 380 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pq_buffer_pkg.sv
// Shared types for the ping-pong buffer drain sequencer: FSM encoding and depth derivation.
package pq_buffer_pkg;

  typedef enum logic [1:0] {
    StInit,
    StIdle,
    StDrain
  } state_e;

  function automatic int unsigned pq_depth(input int unsigned addr_width);
    return 32'd1 << addr_width;
  endfunction

endpackage

// File: rtl/pq_drain_ctrl_if.sv
// Producer port and drained-entry stream of pq_drain_ctrl; slave is the controller side.
interface pq_drain_ctrl_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 4
);

  logic                  prod_ready;
  logic                  prod_rd_en;
  logic                  prod_wr_en;
  logic [ADDR_WIDTH-1:0] prod_rd_addr;
  logic [ADDR_WIDTH-1:0] prod_wr_addr;
  logic [DATA_WIDTH-1:0] prod_din;
  logic [DATA_WIDTH-1:0] prod_dout;

  logic                  out_valid;
  logic                  out_ready;
  logic [ADDR_WIDTH-1:0] out_addr;
  logic [DATA_WIDTH-1:0] out_data;

  modport master (
    input  prod_ready, prod_dout, out_valid, out_addr, out_data,
    output prod_rd_en, prod_wr_en, prod_rd_addr, prod_wr_addr, prod_din, out_ready
  );

  modport slave (
    output prod_ready, prod_dout, out_valid, out_addr, out_data,
    input  prod_rd_en, prod_wr_en, prod_rd_addr, prod_wr_addr, prod_din, out_ready
  );

endinterface

// File: rtl/pq_skid_q.sv
// Two-entry valid/ready queue; falls through combinationally when empty so an
// arriving entry can be taken in the same cycle it is presented.
module pq_skid_q #(
  parameter int unsigned WIDTH = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] mem_q [2];
  logic             head_q, head_d;
  logic [1:0]       count_q, count_d;
  logic             empty, push, pop, tail;

  assign empty     = (count_q == 2'd0);
  assign in_ready  = (count_q != 2'd2);
  assign out_valid = !empty || in_valid;
  assign out_data  = empty ? in_data : mem_q[head_q];
  assign count     = count_q;

  // An entry consumed on the bypass path is never stored.
  assign pop  = !empty && out_ready;
  assign push = in_valid && in_ready && !(empty && out_ready);
  assign tail = head_q ^ count_q[0];

  always_comb begin
    head_d  = head_q ^ pop;
    count_d = count_q + 2'(push) - 2'(pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= 1'b0;
      count_q <= 2'd0;
    end else begin
      head_q  <= head_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[tail] <= in_data;
    end
  end

endmodule

// File: rtl/pq_drain_ctrl.sv
// Ping-pong buffer sequencer: producer passthrough, tick-driven bank swap and zeroing drain sweep.
// Optional PQ_SKIP_ZERO_EN suppresses emission of zero-valued entries during the sweep.
module pq_drain_ctrl
  import pq_buffer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tick,
  output logic                  busy,
  output logic                  drain_done,
  output logic                  overrun,

  pq_drain_ctrl_if.slave        bus,

  output logic                  buf_ctrl,
  output logic                  buf_clear,
  output logic                  buf_rd_en1,
  output logic                  buf_wr_en1,
  output logic [ADDR_WIDTH-1:0] buf_rd_addr1,
  output logic [ADDR_WIDTH-1:0] buf_wr_addr1,
  output logic [DATA_WIDTH-1:0] buf_din1,
  input  logic [DATA_WIDTH-1:0] buf_dout1,
  output logic                  buf_rd_en2,
  output logic                  buf_wr_en2,
  output logic [ADDR_WIDTH-1:0] buf_rd_addr2,
  output logic [ADDR_WIDTH-1:0] buf_wr_addr2,
  output logic [DATA_WIDTH-1:0] buf_din2,
  input  logic [DATA_WIDTH-1:0] buf_dout2
);

  localparam int unsigned DEPTH = pq_depth(ADDR_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] LastAddr = ADDR_WIDTH'(DEPTH - 1);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] init_cnt_q, init_cnt_d;
  // MSB set means all DEPTH reads issued / returned.
  logic [ADDR_WIDTH:0]   issue_cnt_q, issue_cnt_d;
  logic [ADDR_WIDTH:0]   ret_cnt_q, ret_cnt_d;
  logic                  ctrl_q, ctrl_d;
  logic                  pending_q, pending_d;
  logic                  overrun_q, overrun_d;
  logic                  rd_pend_q;
  logic [ADDR_WIDTH-1:0] rd_addr_q;

  logic                  issue, sweep_done, in_init;
  logic                  q_in_valid, q_in_ready;
  logic [1:0]            q_count;
  logic [ADDR_WIDTH+DATA_WIDTH-1:0] q_out_data;

`ifdef PQ_SKIP_ZERO_EN
  assign q_in_valid = rd_pend_q && (buf_dout2 != '0);
`else
  assign q_in_valid = rd_pend_q;
`endif

  // Reads in flight plus queued entries never exceed the queue's two slots.
  assign issue = (state_q == StDrain) && !issue_cnt_q[ADDR_WIDTH] && q_in_ready &&
                 ((q_count + {1'b0, rd_pend_q}) < 2'd2);
  assign sweep_done = (state_q == StDrain) && ret_cnt_q[ADDR_WIDTH] && !rd_pend_q &&
                      (q_count == 2'd0);

  always_comb begin
    state_d     = state_q;
    init_cnt_d  = init_cnt_q;
    issue_cnt_d = issue_cnt_q;
    ret_cnt_d   = ret_cnt_q;
    ctrl_d      = ctrl_q;
    pending_d   = pending_q;
    overrun_d   = overrun_q;

    if (tick && (state_q != StIdle)) begin
      if (pending_q) overrun_d = 1'b1;
      else           pending_d = 1'b1;
    end

    unique case (state_q)
      StInit: begin
        init_cnt_d = init_cnt_q + 1'b1;
        if (init_cnt_q == LastAddr) state_d = StIdle;
      end
      StIdle: begin
        if (tick || pending_q) begin
          ctrl_d      = ~ctrl_q;
          pending_d   = tick && pending_q;
          issue_cnt_d = '0;
          ret_cnt_d   = '0;
          state_d     = StDrain;
        end
      end
      StDrain: begin
        if (issue)      issue_cnt_d = issue_cnt_q + 1'b1;
        if (rd_pend_q)  ret_cnt_d   = ret_cnt_q + 1'b1;
        if (sweep_done) state_d     = StIdle;
      end
      default: state_d = StInit;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StInit;
      init_cnt_q  <= '0;
      issue_cnt_q <= '0;
      ret_cnt_q   <= '0;
      ctrl_q      <= 1'b0;
      pending_q   <= 1'b0;
      overrun_q   <= 1'b0;
      rd_pend_q   <= 1'b0;
      rd_addr_q   <= '0;
    end else begin
      state_q     <= state_d;
      init_cnt_q  <= init_cnt_d;
      issue_cnt_q <= issue_cnt_d;
      ret_cnt_q   <= ret_cnt_d;
      ctrl_q      <= ctrl_d;
      pending_q   <= pending_d;
      overrun_q   <= overrun_d;
      rd_pend_q   <= issue;
      rd_addr_q   <= issue_cnt_q[ADDR_WIDTH-1:0];
    end
  end

  pq_skid_q #(
    .WIDTH(ADDR_WIDTH + DATA_WIDTH)
  ) u_skid_q (
    .clk      (clk),
    .rst      (rst),
    .in_valid (q_in_valid),
    .in_ready (q_in_ready),
    .in_data  ({rd_addr_q, buf_dout2}),
    .out_valid(bus.out_valid),
    .out_ready(bus.out_ready),
    .out_data (q_out_data),
    .count    (q_count)
  );

  assign bus.out_addr = q_out_data[DATA_WIDTH +: ADDR_WIDTH];
  assign bus.out_data = q_out_data[DATA_WIDTH-1:0];

  assign in_init    = (state_q == StInit);
  assign busy       = (state_q != StIdle);
  assign drain_done = sweep_done;
  assign overrun    = overrun_q;
  assign buf_ctrl   = ctrl_q;
  assign buf_clear  = in_init;

  // Port 1: producer passthrough, or the zero-fill walk during INIT.
  assign bus.prod_ready = !in_init;
  assign bus.prod_dout  = buf_dout1;
  assign buf_rd_en1     = in_init ? 1'b0       : bus.prod_rd_en;
  assign buf_wr_en1     = in_init ? 1'b1       : bus.prod_wr_en;
  assign buf_rd_addr1   = in_init ? '0         : bus.prod_rd_addr;
  assign buf_wr_addr1   = in_init ? init_cnt_q : bus.prod_wr_addr;
  assign buf_din1       = in_init ? '0         : bus.prod_din;

  // Port 2: sweep reads, with zero write-back of each entry as its read returns.
  assign buf_rd_en2   = issue;
  assign buf_rd_addr2 = issue_cnt_q[ADDR_WIDTH-1:0];
  assign buf_wr_en2   = rd_pend_q;
  assign buf_wr_addr2 = rd_addr_q;
  assign buf_din2     = '0;

endmodule

// File: tb/tb_pq_drain_ctrl.sv
// Directed bench for pq_drain_ctrl with a behavioural two-bank pq_buffer model.
module tb_pq_drain_ctrl;

  localparam int DW = 8;
  localparam int AW = 4;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tick = 1'b0;
  logic busy, drain_done, overrun;
  logic buf_ctrl, buf_clear;
  logic buf_rd_en1, buf_wr_en1, buf_rd_en2, buf_wr_en2;
  logic [AW-1:0] buf_rd_addr1, buf_wr_addr1, buf_rd_addr2, buf_wr_addr2;
  logic [DW-1:0] buf_din1, buf_din2, buf_dout1, buf_dout2;

  logic preload = 1'b1;
  logic [DW-1:0] bank0 [DEPTH];
  logic [DW-1:0] bank1 [DEPTH];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pq_drain_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  pq_drain_ctrl #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .tick        (tick),
    .busy        (busy),
    .drain_done  (drain_done),
    .overrun     (overrun),
    .bus         (bus),
    .buf_ctrl    (buf_ctrl),
    .buf_clear   (buf_clear),
    .buf_rd_en1  (buf_rd_en1),
    .buf_wr_en1  (buf_wr_en1),
    .buf_rd_addr1(buf_rd_addr1),
    .buf_wr_addr1(buf_wr_addr1),
    .buf_din1    (buf_din1),
    .buf_dout1   (buf_dout1),
    .buf_rd_en2  (buf_rd_en2),
    .buf_wr_en2  (buf_wr_en2),
    .buf_rd_addr2(buf_rd_addr2),
    .buf_wr_addr2(buf_wr_addr2),
    .buf_din2    (buf_din2),
    .buf_dout2   (buf_dout2)
  );

  // Buffer model: port 1 on bank buf_ctrl, port 2 on the other; clear writes both banks.
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < DEPTH; i++) begin
        bank0[i] <= 8'hA5;
        bank1[i] <= 8'h5A;
      end
    end else begin
      if (buf_wr_en1) begin
        if (buf_clear || !buf_ctrl) bank0[buf_wr_addr1] <= buf_din1;
        if (buf_clear || buf_ctrl)  bank1[buf_wr_addr1] <= buf_din1;
      end
      if (buf_wr_en2) begin
        if (buf_ctrl) bank0[buf_wr_addr2] <= buf_din2;
        else          bank1[buf_wr_addr2] <= buf_din2;
      end
      if (buf_rd_en1) buf_dout1 <= buf_ctrl ? bank1[buf_rd_addr1] : bank0[buf_rd_addr1];
      if (buf_rd_en2) buf_dout2 <= buf_ctrl ? bank0[buf_rd_addr2] : bank1[buf_rd_addr2];
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_active(input int base, input bit tick_last);
    for (int k = 0; k < DEPTH; k++) begin
      bus.prod_wr_en   = 1'b1;
      bus.prod_wr_addr = AW'(k);
      bus.prod_din     = DW'(k + base);
      tick             = tick_last && (k == DEPTH - 1);
      step();
    end
    bus.prod_wr_en = 1'b0;
    tick = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.prod_wr_en   = 1'b1;
    bus.prod_wr_addr = 4'd3;
    bus.prod_din     = 8'hFF;
    step();
    preload = 1'b0;
    step();
    checks++;
    if ({bus.out_valid, drain_done, overrun, busy, bus.prod_ready, buf_ctrl, buf_clear,
         buf_rd_en2, buf_wr_en2} !== 9'b000100100) begin
      failures++;
      $display("FAIL reset_values: got %b want %b", {bus.out_valid, drain_done, overrun, busy,
               bus.prod_ready, buf_ctrl, buf_clear, buf_rd_en2, buf_wr_en2}, 9'b000100100);
    end
    checks++;
    if ({buf_wr_en1, buf_wr_addr1, buf_din1} !== {1'b1, 4'd0, 8'd0}) begin
      failures++;
      $display("FAIL init_port1: got %h want %h", {buf_wr_en1, buf_wr_addr1, buf_din1},
               {1'b1, 4'd0, 8'd0});
    end
    rst = 1'b0;
    repeat (15) step();
    bus.prod_wr_en = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL init_busy_15: got %b want 1", busy);
    end
    step();
    checks++;
    if ({busy, bus.prod_ready} !== 2'b01) begin
      failures++;
      $display("FAIL init_done: got busy,ready=%b want 01", {busy, bus.prod_ready});
    end
    for (int i = 0; i < DEPTH; i++) begin
      checks++;
      if ({bank0[i], bank1[i]} !== 16'h0) begin
        failures++;
        $display("FAIL reset_zero[%0d]: got %h want 0000", i, {bank0[i], bank1[i]});
      end
    end
  endtask

  // Last producer write shares its cycle with the swapping tick.
  task automatic test_drain_stream();
    fill_active(1, 1'b1);
    checks++;
    if ({buf_ctrl, buf_rd_en2, buf_rd_addr2, busy, bus.out_valid} !== {1'b1, 1'b1, 4'd0, 2'b10})
    begin
      failures++;
      $display("FAIL swap_first_read: got %b want %b",
               {buf_ctrl, buf_rd_en2, buf_rd_addr2, busy, bus.out_valid}, 8'b11000010);
    end
    for (int k = 0; k < DEPTH; k++) begin
      step();
      checks++;
      if ({bus.out_valid, bus.out_addr, bus.out_data, drain_done} !==
          {1'b1, AW'(k), DW'(k + 1), 1'b0}) begin
        failures++;
        $display("FAIL stream_beat[%0d]: got %h want %h", k,
                 {bus.out_valid, bus.out_addr, bus.out_data, drain_done},
                 {1'b1, AW'(k), DW'(k + 1), 1'b0});
      end
    end
    step();
    checks++;
    if (drain_done !== 1'b1) begin
      failures++;
      $display("FAIL drain_done_t18: got %b want 1", drain_done);
    end
    step();
    checks++;
    if ({drain_done, busy} !== 2'b00) begin
      failures++;
      $display("FAIL drain_end: got done,busy=%b want 00", {drain_done, busy});
    end
    for (int i = 0; i < DEPTH; i++) begin
      checks++;
      if (bank0[i] !== 8'h0) begin
        failures++;
        $display("FAIL drained_zero[%0d]: got %h want 00", i, bank0[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    int nbeats = 0;
    bit hold = 1'b0;
    bit seen_done = 1'b0;
    logic [AW+DW-1:0] prev = '0;
    fill_active(1, 1'b0);
    tick = 1'b1;
    step();
    tick = 1'b0;
    for (int c = 0; c < 200; c++) begin
      bus.out_ready = pat[c % 4];
      if (hold) begin
        checks++;
        if ({bus.out_valid, bus.out_addr, bus.out_data} !== {1'b1, prev}) begin
          failures++;
          $display("FAIL bp_stable: got %h want %h",
                   {bus.out_valid, bus.out_addr, bus.out_data}, {1'b1, prev});
        end
      end
      if (drain_done) begin
        seen_done = 1'b1;
        break;
      end
      if (bus.out_valid && bus.out_ready) begin
        checks++;
        if ({bus.out_addr, bus.out_data} !== {AW'(nbeats), DW'(nbeats + 1)}) begin
          failures++;
          $display("FAIL bp_beat[%0d]: got %h want %h", nbeats, {bus.out_addr, bus.out_data},
                   {AW'(nbeats), DW'(nbeats + 1)});
        end
        nbeats++;
      end
      hold = bus.out_valid && !bus.out_ready;
      prev = {bus.out_addr, bus.out_data};
      step();
    end
    bus.out_ready = 1'b1;
    checks++;
    if (!seen_done || nbeats != DEPTH) begin
      failures++;
      $display("FAIL bp_count: got done=%0d beats=%0d want done=1 beats=%0d",
               seen_done, nbeats, DEPTH);
    end
    step();
  endtask

  task automatic test_overrun();
    bit seen = 1'b0;
    tick = 1'b1;
    step();
    tick = 1'b0;
    step();
    step();
    tick = 1'b1;
    step();
    tick = 1'b0;
    checks++;
    if ({overrun, buf_ctrl} !== 2'b01) begin
      failures++;
      $display("FAIL pend_first: got overrun,ctrl=%b want 01", {overrun, buf_ctrl});
    end
    step();
    tick = 1'b1;
    step();
    tick = 1'b0;
    checks++;
    if (overrun !== 1'b1) begin
      failures++;
      $display("FAIL overrun_set: got %b want 1", overrun);
    end
    for (int c = 0; c < 50 && !seen; c++) begin
      if (drain_done) seen = 1'b1;
      else step();
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL ovr_wait_done: got timeout want drain_done");
    end
    step();
    checks++;
    if ({busy, buf_ctrl} !== 2'b01) begin
      failures++;
      $display("FAIL pend_idle: got busy,ctrl=%b want 01", {busy, buf_ctrl});
    end
    step();
    checks++;
    if ({busy, buf_ctrl} !== 2'b10) begin
      failures++;
      $display("FAIL pend_swap: got busy,ctrl=%b want 10", {busy, buf_ctrl});
    end
    seen = 1'b0;
    for (int c = 0; c < 50 && !seen; c++) begin
      if (drain_done) seen = 1'b1;
      step();
    end
    checks++;
    if (!seen || overrun !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL ovr_second: got done=%0d overrun=%b busy=%b want 1 1 0",
               seen, overrun, busy);
    end
  endtask

  task automatic test_zero_sweep();
`ifdef PQ_SKIP_ZERO_EN
    int exp_beats = 0;
`else
    int exp_beats = DEPTH;
`endif
    for (int s = 0; s < 2; s++) begin
      int nbeats = 0;
      bit seen = 1'b0;
      tick = 1'b1;
      step();
      tick = 1'b0;
      for (int c = 0; c < 50 && !seen; c++) begin
        if (drain_done) seen = 1'b1;
        else if (bus.out_valid) begin
          checks++;
          if ({bus.out_addr, bus.out_data} !== {AW'(nbeats), 8'h00}) begin
            failures++;
            $display("FAIL zero_beat[%0d]: got %h want %h", nbeats,
                     {bus.out_addr, bus.out_data}, {AW'(nbeats), 8'h00});
          end
          nbeats++;
        end
        step();
      end
      checks++;
      if (!seen || nbeats != exp_beats) begin
        failures++;
        $display("FAIL zero_count[%0d]: got done=%0d beats=%0d want done=1 beats=%0d",
                 s, seen, nbeats, exp_beats);
      end
    end
  endtask

  task automatic test_rst_mid_drain();
    bit seen = 1'b0;
    fill_active(8'h10, 1'b0);
    tick = 1'b1;
    step();
    tick = 1'b0;
    for (int c = 0; c < 30 && !seen; c++) begin
      step();
      if (bus.out_valid && bus.out_addr == 4'd5) seen = 1'b1;
    end
    checks++;
    if (!seen || bus.out_data !== 8'h15) begin
      failures++;
      $display("FAIL mid_beat5: got seen=%0d data=%h want seen=1 data=15", seen, bus.out_data);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if ({bus.out_valid, busy, bus.prod_ready, buf_clear, buf_ctrl} !== 5'b01010) begin
      failures++;
      $display("FAIL mid_rst: got %b want 01010",
               {bus.out_valid, busy, bus.prod_ready, buf_clear, buf_ctrl});
    end
    repeat (16) step();
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL mid_reinit_busy: got %b want 0", busy);
    end
    for (int i = 0; i < DEPTH; i++) begin
      checks++;
      if ({bank0[i], bank1[i]} !== 16'h0) begin
        failures++;
        $display("FAIL mid_zero[%0d]: got %h want 0000", i, {bank0[i], bank1[i]});
      end
    end
  endtask

  initial begin
    bus.prod_rd_en   = 1'b0;
    bus.prod_wr_en   = 1'b0;
    bus.prod_rd_addr = '0;
    bus.prod_wr_addr = '0;
    bus.prod_din     = '0;
    bus.out_ready    = 1'b1;
    test_reset();
    test_drain_stream();
    test_backpressure();
    test_overrun();
    test_zero_sweep();
    test_rst_mid_drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
